// File: rtl/ata_pio_timing_ctrl_if.sv
// Bus bundle between the EP73xx static-memory side and the IDE connector.
// The master side is the CPU plus drive; the slave side is the PIO cycle engine.
interface ata_pio_timing_ctrl_if;
  logic       cs5;
  logic       moe;
  logic       mwe;
  logic [3:0] a;
  logic       exprdy;
  logic       cs0;
  logic       cs1;
  logic       dior;
  logic       diow;
  logic       rw;
  logic       oe;
  logic [2:0] da;
  logic       intrq;
  logic       eint;
  logic       iordy;

  modport master (
    output cs5, moe, mwe, a, intrq, iordy,
    input  exprdy, cs0, cs1, dior, diow, rw, oe, da, eint
  );

  modport slave (
    input  cs5, moe, mwe, a, intrq, iordy,
    output exprdy, cs0, cs1, dior, diow, rw, oe, da, eint
  );
endinterface

// File: rtl/ata_pio_timing_ctrl.sv
// ATA PIO host cycle engine: turns one CS5 access into one timed drive cycle
// with run-time setup/active/recovery, synchronised IORDY and a wait timeout.
module ata_pio_timing_ctrl #(
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned IORDY_SAMPLE = 3,
  parameter int unsigned TIMEOUT_CLKS = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  ata_pio_timing_ctrl_if.slave bus,
  input  logic [CNT_W-1:0]     setup_clks,
  input  logic [CNT_W-1:0]     active_clks,
  input  logic [CNT_W-1:0]     recover_clks,
  output logic                 busy,
  output logic                 timeout_err
);
  typedef enum logic [2:0] {IDLE, ARM, SETUP, ACTIVE, WAIT_IORDY, HOLD, RECOVER} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAMPLE  = CNT_W'(IORDY_SAMPLE);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] setup_l, active_l, recover_l;
  logic [CNT_W-1:0] setup_last, active_last, recover_last;
  logic [1:0]       sync_q;
  logic             iordy_s, armed_q, start, finish;
  logic             exprdy_q, cs0_q, cs1_q, dior_q, diow_q, rw_q, to_q;
  logic             exprdy_d, cs0_d, cs1_d, dior_d, diow_d, rw_d, to_d;

  function automatic logic [CNT_W-1:0] nonzero(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign iordy_s      = sync_q[1];
  assign setup_last   = setup_l - ONE;
  assign recover_last = recover_l - ONE;
  // max(active, IORDY_SAMPLE+1) - 1 keeps the sample point inside ACTIVE
  assign active_last  = (active_l > SAMPLE) ? active_l - ONE : SAMPLE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    exprdy_d = exprdy_q;
    cs0_d    = cs0_q;
    cs1_d    = cs1_q;
    dior_d   = dior_q;
    diow_d   = diow_q;
    rw_d     = rw_q;
    to_d     = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: if (!bus.cs5 && armed_q) begin
        start    = 1'b1;
        cs0_d    = bus.a[3];
        cs1_d    = !bus.a[3];
        exprdy_d = 1'b0;
        state_d  = ARM;
      end
      ARM: begin
        cnt_d = '0;
        if (!bus.mwe) begin
          rw_d    = 1'b1;
          state_d = SETUP;
        end else if (!bus.moe) begin
          rw_d    = 1'b0;
          state_d = SETUP;
        end else if (bus.cs5) begin
          cs0_d    = 1'b1;
          cs1_d    = 1'b1;
          exprdy_d = 1'b1;
          state_d  = IDLE;
        end
      end
      SETUP: if (cnt_q == setup_last) begin
        dior_d  = rw_q;
        diow_d  = !rw_q;
        cnt_d   = '0;
        state_d = ACTIVE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      ACTIVE: if (cnt_q == SAMPLE && !iordy_s) begin
        wcnt_d  = '0;
        state_d = WAIT_IORDY;
      end else if (cnt_q == active_last) begin
        finish = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      WAIT_IORDY: if (iordy_s) begin
        finish = 1'b1;
      end else if (wcnt_q == TO_LAST) begin
        finish = 1'b1;
        to_d   = 1'b1;
      end else begin
        wcnt_d = wcnt_q + TO_W'(1);
      end
      HOLD: begin
        dior_d  = 1'b1;
        cnt_d   = '0;
        state_d = RECOVER;
      end
      RECOVER: if (cnt_q == recover_last) begin
        cs0_d   = 1'b1;
        cs1_d   = 1'b1;
        rw_d    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      default: state_d = IDLE;
    endcase
    // Completion is folded into the exit edge of ACTIVE/WAIT so a write strobe
    // is exactly active_clks wide and exprdy rises together with diow.
    if (finish) begin
      exprdy_d = 1'b1;
      cnt_d    = '0;
      if (rw_q) begin
        diow_d  = 1'b1;
        state_d = RECOVER;
      end else begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      setup_l   <= '0;
      active_l  <= '0;
      recover_l <= '0;
      sync_q    <= '1;
      armed_q   <= 1'b1;
      exprdy_q  <= 1'b1;
      cs0_q     <= 1'b1;
      cs1_q     <= 1'b1;
      dior_q    <= 1'b1;
      diow_q    <= 1'b1;
      rw_q      <= 1'b1;
      to_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      sync_q   <= {sync_q[0], bus.iordy};
      exprdy_q <= exprdy_d;
      cs0_q    <= cs0_d;
      cs1_q    <= cs1_d;
      dior_q   <= dior_d;
      diow_q   <= diow_d;
      rw_q     <= rw_d;
      to_q     <= to_d;
      if (start) begin
        setup_l   <= nonzero(setup_clks);
        active_l  <= nonzero(active_clks);
        recover_l <= nonzero(recover_clks);
        armed_q   <= 1'b0;
      end else if (bus.cs5) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign bus.exprdy  = exprdy_q;
  assign bus.cs0     = cs0_q;
  assign bus.cs1     = cs1_q;
  assign bus.dior    = dior_q;
  assign bus.diow    = diow_q;
  assign bus.rw      = rw_q;
  assign bus.oe      = cs0_q & cs1_q;
  assign bus.da      = bus.a[2:0];
  assign bus.eint    = !bus.intrq;
  assign busy        = (state_q != IDLE);
  assign timeout_err = to_q;
endmodule

// File: tb/tb_ata_pio_timing_ctrl.sv
// Bench for ata_pio_timing_ctrl: an edge-time model predicts every output each
// cycle, and directed scenarios pin measured strobe timing to literal values.
module tb_ata_pio_timing_ctrl;
  localparam int CNT_W   = 6;
  localparam int TO_W    = 8;
  localparam int SAMPLE  = 3;
  localparam int TIMEOUT = 200;
  localparam int INF     = 1 << 30;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] setup_clks, active_clks, recover_clks;
  logic             busy, timeout_err;

  ata_pio_timing_ctrl_if bus();

  ata_pio_timing_ctrl #(
    .CNT_W(CNT_W), .TO_W(TO_W), .IORDY_SAMPLE(SAMPLE), .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .setup_clks(setup_clks), .active_clks(active_clks), .recover_clks(recover_clks),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Model: each drive cycle is a set of absolute edge numbers at which outputs change.
  int n = 0;
  bit m_busy = 0, m_armed = 1, s1 = 1, s2 = 1;
  bit m_wr = 0, m_sel = 0, m_wait = 0, m_timed = 0;
  int t0 = INF, t_arm = INF, t_fall = INF, t_samp = INF, t_norm = INF;
  int t_done = INF, t_rise = INF, t_csr = INF, w0 = INF;
  int m_setup = 1, m_act = 1, m_rec = 1;

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic m_clear();
    m_busy = 0; m_armed = 1; s1 = 1; s2 = 1; m_wait = 0; m_timed = 0;
    t0 = INF; t_arm = INF; t_fall = INF; t_samp = INF; t_norm = INF;
    t_done = INF; t_rise = INF; t_csr = INF; w0 = INF;
  endtask

  task automatic m_finish(input int at);
    t_done = at;
    t_rise = m_wr ? at : at + 1;
    t_csr  = t_rise + m_rec;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear();
    end else begin
      bit was_busy, rdy;
      n++;
      rdy = s2; s2 = s1; s1 = bus.iordy;
      was_busy = m_busy;
      if (m_busy) begin
        if (t_arm == INF) begin
          if (!bus.mwe || !bus.moe) begin
            m_wr   = !bus.mwe;
            t_arm  = n;
            t_fall = n + m_setup;
            t_samp = t_fall + 1 + SAMPLE;
            t_norm = t_fall + ((m_act > SAMPLE + 1) ? m_act : SAMPLE + 1);
          end else if (bus.cs5) begin
            t_done = n; t_csr = n; m_busy = 0;
          end
        end else if (t_done == INF) begin
          if (n == t_samp && !rdy) begin
            m_wait = 1; w0 = n + 1;
          end else if (!m_wait && n == t_norm) begin
            m_finish(n);
          end else if (m_wait && n >= w0) begin
            if (rdy) m_finish(n);
            else if (n - w0 == TIMEOUT - 1) begin
              m_finish(n); m_timed = 1;
            end
          end
        end else if (n == t_csr) begin
          m_busy = 0;
        end
      end
      if (!was_busy && !bus.cs5 && m_armed) begin
        m_busy = 1; m_armed = 0; m_wait = 0; m_timed = 0;
        m_sel = bus.a[3];
        m_setup = nz(int'(setup_clks));
        m_act = nz(int'(active_clks));
        m_rec = nz(int'(recover_clks));
        t0 = n; t_arm = INF; t_fall = INF; t_samp = INF; t_norm = INF;
        t_done = INF; t_rise = INF; t_csr = INF; w0 = INF;
      end else if (bus.cs5) begin
        m_armed = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit cs_low, ex_low, st_low, rd_dir;
    logic [11:0] got, exp;
    cs_low = (n >= t0) && (n < t_csr);
    ex_low = (n >= t0) && (n < t_done);
    st_low = (n >= t_fall) && (n < t_rise);
    rd_dir = (n >= t_arm) && (n < t_csr) && !m_wr;
    exp = {!ex_low, !(cs_low && !m_sel), !(cs_low && m_sel),
           !(st_low && !m_wr), !(st_low && m_wr), !rd_dir,
           !cs_low, cs_low, (m_timed && n == t_done), bus.a[2:0], !bus.intrq};
    got = {bus.exprdy, bus.cs0, bus.cs1, bus.dior, bus.diow, bus.rw,
           bus.oe, busy, timeout_err, bus.da, bus.eint};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle n=%0d: got %b expected %b", n, got, exp);
    end
  end

  // Edge monitor for literal timing checks.
  int k = 0, cs_fall, cs_rise, st_fall, st_rise, ex_rise, strobes, to_pulses, iordy_k;
  bit saw_cs1, ok;
  logic p_cs = 1'b1, p_st = 1'b1, p_ex = 1'b1;

  always @(negedge clk) begin
    logic cs_n, st_n;
    k++;
    cs_n = bus.cs0 & bus.cs1;
    st_n = bus.dior & bus.diow;
    if (p_cs && !cs_n) cs_fall = k;
    if (!p_cs && cs_n) cs_rise = k;
    if (p_st && !st_n) begin st_fall = k; strobes++; end
    if (!p_st && st_n) st_rise = k;
    if (!p_ex && bus.exprdy) ex_rise = k;
    if (!bus.cs1) saw_cs1 = 1;
    if (timeout_err) to_pulses++;
    p_cs = cs_n; p_st = st_n; p_ex = bus.exprdy;
  end

  task automatic clr_trace();
    cs_fall = -1; cs_rise = -1; st_fall = -1; st_rise = -1; ex_rise = -1;
    strobes = 0; to_pulses = 0; saw_cs1 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic release_cpu();
    bus.cs5 = 1'b1; bus.moe = 1'b1; bus.mwe = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (busy && bus.exprdy) done = 1;
    end
    check(name, done, 1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int i = 0; i < 50 && !idle; i++) begin
      step();
      if (!busy) idle = 1;
    end
    check(name, idle, 1);
    step();
  endtask

  task automatic cpu_cycle(input logic [3:0] addr, input bit wr, input int budget);
    bus.a = addr; bus.cs5 = 1'b0;
    if (wr) bus.mwe = 1'b0; else bus.moe = 1'b0;
    wait_done("cpu_done", budget);
    release_cpu();
    wait_idle("cpu_idle");
  endtask

  initial begin
    release_cpu();
    bus.a = 4'h0; bus.intrq = 1'b0; bus.iordy = 1'b1;
    setup_clks = 6'd2; active_clks = 6'd6; recover_clks = 6'd2;
    repeat (3) @(posedge clk);
    #2;
    check("rst_exprdy", bus.exprdy, 1);
    check("rst_cs0", bus.cs0, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Read from cs0, register 7.
    clr_trace();
    cpu_cycle(4'h7, 0, 60);
    check("rd_setup", st_fall - cs_fall, 3);
    check("rd_width", st_rise - st_fall, 7);
    check("rd_exprdy_lead", st_rise - ex_rise, 1);
    check("rd_recover", cs_rise - st_rise, 2);
    check("rd_count", strobes, 1);
    check("rd_da", bus.da, 7);
    check("model_fall", t_fall - t0, 3);
    check("model_rise", t_rise - t_fall, 7);

    // Write to cs1, register 6, with interrupt asserted.
    clr_trace();
    bus.intrq = 1'b1;
    cpu_cycle(4'hE, 1, 60);
    check("wr_width", st_rise - st_fall, 6);
    check("wr_exprdy_with_diow", st_rise - ex_rise, 0);
    check("wr_recover", cs_rise - st_rise, 2);
    check("wr_cs1", saw_cs1, 1);
    check("wr_eint", bus.eint, 0);
    bus.intrq = 1'b0;

    // IORDY low at the sample point, released later.
    clr_trace();
    bus.iordy = 1'b0;
    repeat (3) step();
    bus.a = 4'h3; bus.cs5 = 1'b0; bus.moe = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (!bus.dior) ok = 1;
    end
    check("iordy_strobe", ok, 1);
    repeat (20) step();
    bus.iordy = 1'b1;
    iordy_k = k + 1;
    wait_done("iordy_done", 40);
    release_cpu();
    wait_idle("iordy_idle");
    check("iordy_exprdy", ex_rise - iordy_k, 3);
    check("iordy_dior", st_rise - iordy_k, 4);
    check("iordy_no_timeout", to_pulses, 0);

    // IORDY stuck low: timeout.
    clr_trace();
    bus.iordy = 1'b0;
    repeat (3) step();
    cpu_cycle(4'h1, 0, 400);
    check("to_pulses", to_pulses, 1);
    check("to_length", ex_rise - st_fall, 204);
    check("to_idle", busy, 0);
    bus.iordy = 1'b1;
    repeat (3) step();

    // cs5 held low across a whole cycle: one drive cycle per cs5 low phase.
    clr_trace();
    bus.a = 4'h2; bus.cs5 = 1'b0; bus.moe = 1'b0;
    repeat (30) step();
    check("hold_one_cycle", strobes, 1);
    release_cpu();
    repeat (2) step();
    bus.cs5 = 1'b0; bus.moe = 1'b0;
    repeat (30) step();
    check("rearm_second_cycle", strobes, 2);
    release_cpu();
    repeat (3) step();

    // cs5 rising in ARM aborts without a strobe.
    clr_trace();
    bus.cs5 = 1'b0;
    repeat (2) step();
    bus.cs5 = 1'b1;
    repeat (3) step();
    check("abort_no_strobe", strobes, 0);
    check("abort_cs_width", cs_rise - cs_fall, 2);
    check("abort_idle", busy, 0);

    // Zero timings behave as one clock; active is stretched past the sample point.
    setup_clks = '0; active_clks = '0; recover_clks = '0;
    clr_trace();
    cpu_cycle(4'h5, 1, 60);
    check("zero_setup", st_fall - cs_fall, 2);
    check("zero_width", st_rise - st_fall, 4);
    check("zero_recover", cs_rise - st_rise, 1);
    setup_clks = 6'd2; active_clks = 6'd6; recover_clks = 6'd2;

    // Reset during ACTIVE of a read.
    clr_trace();
    bus.a = 4'h7; bus.cs5 = 1'b0; bus.moe = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (!bus.dior) ok = 1;
    end
    check("rst_mid_strobe", ok, 1);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("rst_mid_dior", bus.dior, 1);
    check("rst_mid_cs0", bus.cs0, 1);
    check("rst_mid_exprdy", bus.exprdy, 1);
    release_cpu();
    repeat (2) step();
    reset = 1'b0;
    step();
    clr_trace();
    cpu_cycle(4'h7, 0, 60);
    check("post_rst_width", st_rise - st_fall, 7);
    check("post_rst_count", strobes, 1);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
